// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
//  Shared definitions for the FFT post-processing blocks.
//   mag_w(w)      : squared-magnitude width for an FFT component width w (2*w+1)
//   idx_w(n)      : bin-index width for an n-point FFT
//   peak_state_t  : peak-search FSM states (SCAN, LOAD)
// ----------------------------------------------------------------------------
package fft_pkg;

   function automatic int mag_w(input int w);
      return 2 * w + 1;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [0:0] {
      SCAN = 1'b0,
      LOAD = 1'b1
   } peak_state_t;

endpackage

// File: rtl/fft_bin_counter.sv
// ----------------------------------------------------------------------------
// fft_bin_counter
//  Tracks which FFT bin the current magnitude beat belongs to.
//  Ports:
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   mag_valid       : a bin is presented this cycle
//   mag_sop         : with mag_valid, this beat is bin 0 (resynchronises)
//   bin             : index of the bin presented this cycle (valid with mag_valid)
//   in_window       : valid beat with BIN_LO <= bin <= BIN_HI
//   last_in_window  : valid beat at bin BIN_HI
// ----------------------------------------------------------------------------
module fft_bin_counter
   import fft_pkg::*;
#(
   parameter int NFFT   = 256,
   parameter int BIN_LO = 1,
   parameter int BIN_HI = 127,
   localparam int IW    = idx_w(NFFT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mag_valid,
   input  logic          mag_sop,
   output logic [IW-1:0] bin,
   output logic          in_window,
   output logic          last_in_window
);

   logic [IW-1:0] bin_cnt_reg;
   logic [IW-1:0] bin_cnt_next;
   logic          lo_ok;
   logic          hi_ok;

   // A start-of-packet beat is bin 0 regardless of where the count stood.
   assign bin = (mag_valid && mag_sop) ? '0 : bin_cnt_reg;

   always_comb begin
      bin_cnt_next = bin_cnt_reg;
      if (mag_valid) begin
         if (bin == IW'(NFFT - 1))
            bin_cnt_next = '0;
         else
            bin_cnt_next = bin + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bin_cnt_reg <= '0;
      else
         bin_cnt_reg <= bin_cnt_next;
   end

   // Window bounds that coincide with the index range need no comparator.
   generate
      if (BIN_LO == 0) begin : g_lo_open
         assign lo_ok = 1'b1;
      end else begin : g_lo_cmp
         assign lo_ok = (bin >= IW'(BIN_LO));
      end
      if (BIN_HI == NFFT - 1) begin : g_hi_open
         assign hi_ok = 1'b1;
      end else begin : g_hi_cmp
         assign hi_ok = (bin <= IW'(BIN_HI));
      end
   endgenerate

   assign in_window      = mag_valid && lo_ok && hi_ok;
   assign last_in_window = mag_valid && (bin == IW'(BIN_HI));

endmodule

// File: rtl/fft_peak_bin.sv
// ----------------------------------------------------------------------------
// fft_peak_bin
//  Finds the largest squared magnitude within bins BIN_LO..BIN_HI of each FFT
//  frame and reports {bin, magnitude} once per frame over valid/ready.
//  Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   mag_valid    : mag_sq carries one bin this cycle
//   mag_sop      : with mag_valid, this beat is bin 0
//   mag_sq       : unsigned squared magnitude, MW = 2*W+1 bits
//   peak_thresh  : (PEAK_THRESH_EN only) results with max <= thresh are discarded
//   peak_valid   : result pending
//   peak_ready   : consumer accepts when peak_valid && peak_ready
//   peak_bin     : index of the peak bin
//   peak_mag     : magnitude of the peak bin
//   overrun      : sticky, a frame result was dropped while one was pending
//  Build option: define PEAK_THRESH_EN to add the peak_thresh input.
// ----------------------------------------------------------------------------
module fft_peak_bin
   import fft_pkg::*;
#(
   parameter int W      = 16,
   parameter int NFFT   = 256,
   parameter int BIN_LO = 1,
   parameter int BIN_HI = 127,
   localparam int MW    = mag_w(W),
   localparam int IW    = idx_w(NFFT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mag_valid,
   input  logic          mag_sop,
   input  logic [MW-1:0] mag_sq,
`ifdef PEAK_THRESH_EN
   input  logic [MW-1:0] peak_thresh,
`endif
   output logic          peak_valid,
   input  logic          peak_ready,
   output logic [IW-1:0] peak_bin,
   output logic [MW-1:0] peak_mag,
   output logic          overrun
);

   logic [IW-1:0] bin_idx;
   logic          in_window;
   logic          last_in_window;
   logic          sop_beat;

   peak_state_t   state_reg;
   peak_state_t   state_next;

   logic [MW-1:0] max_reg;
   logic [IW-1:0] idx_reg;
   logic          have_reg;
   logic          have_eff;
   logic          take;
   logic [MW-1:0] cand_mag;
   logic [IW-1:0] cand_idx;
   logic          emit;
   logic          accept;
   logic          out_free;

   logic          peak_valid_reg;
   logic [IW-1:0] peak_bin_reg;
   logic [MW-1:0] peak_mag_reg;
   logic          overrun_reg;

   fft_bin_counter #(
      .NFFT   (NFFT),
      .BIN_LO (BIN_LO),
      .BIN_HI (BIN_HI)
   ) u_bin_counter (
      .clk            (clk),
      .reset          (reset),
      .mag_valid      (mag_valid),
      .mag_sop        (mag_sop),
      .bin            (bin_idx),
      .in_window      (in_window),
      .last_in_window (last_in_window)
   );

   assign sop_beat = mag_valid && mag_sop;

   // The running max only counts as seeded while scanning a frame that has
   // not been restarted: LOAD (cycle after the BIN_HI beat) and an SOP beat
   // both discard it, so the next in-window beat always loads.
   assign have_eff = have_reg && !sop_beat && (state_reg == SCAN);
   assign take     = in_window && (!have_eff || (mag_sq > max_reg));
   assign cand_mag = take ? mag_sq  : max_reg;
   assign cand_idx = take ? bin_idx : idx_reg;

   // The result includes the BIN_HI beat itself and is captured on that
   // beat's edge, so peak_valid rises one cycle after it.
`ifdef PEAK_THRESH_EN
   assign emit = last_in_window && (cand_mag > peak_thresh);
`else
   assign emit = last_in_window;
`endif

   assign accept   = peak_valid_reg && peak_ready;
   assign out_free = !peak_valid_reg || peak_ready;

   assign state_next = last_in_window ? LOAD : SCAN;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= SCAN;
      else
         state_reg <= state_next;
   end

   // Running maximum
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_reg  <= '0;
         idx_reg  <= IW'(BIN_LO);
         have_reg <= 1'b0;
      end else if (take) begin
         max_reg  <= mag_sq;
         idx_reg  <= bin_idx;
         have_reg <= 1'b1;
      end else if (sop_beat || (state_reg == LOAD)) begin
         max_reg  <= '0;
         idx_reg  <= IW'(BIN_LO);
         have_reg <= 1'b0;
      end
   end

   // Output holding registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_valid_reg <= 1'b0;
         peak_bin_reg   <= '0;
         peak_mag_reg   <= '0;
         overrun_reg    <= 1'b0;
      end else begin
         if (emit && out_free) begin
            peak_valid_reg <= 1'b1;
            peak_bin_reg   <= cand_idx;
            peak_mag_reg   <= cand_mag;
         end else begin
            // A result arriving while the previous one is still held is lost.
            if (emit)
               overrun_reg <= 1'b1;
            if (accept) begin
               peak_valid_reg <= 1'b0;
               peak_bin_reg   <= '0;
               peak_mag_reg   <= '0;
            end
         end
      end
   end

   assign peak_valid = peak_valid_reg;
   assign peak_bin   = peak_bin_reg;
   assign peak_mag   = peak_mag_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fft_peak_bin.sv
module tb_fft_peak_bin;

   localparam int W      = 16;
   localparam int NFFT   = 256;
   localparam int BIN_HI = 127;
   localparam int MW     = 2 * W + 1;
   localparam int IW     = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          mag_valid;
   logic          mag_sop;
   logic [MW-1:0] mag_sq;
   logic          peak_valid;
   logic          peak_ready;
   logic [IW-1:0] peak_bin;
   logic [MW-1:0] peak_mag;
   logic          overrun;
`ifdef PEAK_THRESH_EN
   logic [MW-1:0] peak_thresh;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [MW-1:0] fmag [0:NFFT-1];

   always #5 clk = ~clk;

   fft_peak_bin dut (
      .clk         (clk),
      .reset       (reset),
      .mag_valid   (mag_valid),
      .mag_sop     (mag_sop),
      .mag_sq      (mag_sq),
`ifdef PEAK_THRESH_EN
      .peak_thresh (peak_thresh),
`endif
      .peak_valid  (peak_valid),
      .peak_ready  (peak_ready),
      .peak_bin    (peak_bin),
      .peak_mag    (peak_mag),
      .overrun     (overrun)
   );

   task automatic fill(input logic [MW-1:0] v);
      for (int i = 0; i < NFFT; i++) fmag[i] = v;
   endtask

   // Drives one full frame from fmag; checks the result on the cycle after the
   // BIN_HI beat (latency 1).
   task automatic drive_frame(input string name, input bit use_sop, input bit gaps,
                              input bit exp_valid, input logic [IW-1:0] exp_bin,
                              input logic [MW-1:0] exp_mag);
      for (int b = 0; b < NFFT; b++) begin
         @(negedge clk);
         if (b == BIN_HI + 1) begin
            $display("frame %s: peak_valid=%b peak_bin=%0d peak_mag=%0d overrun=%b",
                     name, peak_valid, peak_bin, peak_mag, overrun);
            vectors++;
            if (peak_valid !== exp_valid) begin
               miscompares++;
               $display("FAIL %s.valid: got %b expected %b", name, peak_valid, exp_valid);
            end
            if (exp_valid) begin
               vectors++;
               if (peak_bin !== exp_bin) begin
                  miscompares++;
                  $display("FAIL %s.bin: got %0d expected %0d", name, peak_bin, exp_bin);
               end
               vectors++;
               if (peak_mag !== exp_mag) begin
                  miscompares++;
                  $display("FAIL %s.mag: got %0d expected %0d", name, peak_mag, exp_mag);
               end
            end
         end
         if (gaps && (b % 7 == 3)) begin
            mag_valid = 1'b0;
            mag_sop   = 1'b0;
            @(negedge clk);
         end
         mag_valid = 1'b1;
         mag_sop   = use_sop && (b == 0);
         mag_sq    = fmag[b];
      end
      @(negedge clk);
      mag_valid = 1'b0;
      mag_sop   = 1'b0;
      mag_sq    = '0;
   endtask

   // Drives bins 0..n-1 of a frame (SOP on bin 0) and then goes idle.
   task automatic drive_partial(input int n);
      for (int b = 0; b < n; b++) begin
         @(negedge clk);
         mag_valid = 1'b1;
         mag_sop   = (b == 0);
         mag_sq    = fmag[b];
      end
      @(negedge clk);
      mag_valid = 1'b0;
      mag_sop   = 1'b0;
      mag_sq    = '0;
   endtask

   task automatic check_idle_outputs(input string name, input logic exp_overrun);
      $display("check %s: peak_valid=%b peak_bin=%0d peak_mag=%0d overrun=%b",
               name, peak_valid, peak_bin, peak_mag, overrun);
      vectors++;
      if (peak_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s.valid: got %b expected 0", name, peak_valid);
      end
      vectors++;
      if (peak_bin !== '0) begin
         miscompares++;
         $display("FAIL %s.bin: got %0d expected 0", name, peak_bin);
      end
      vectors++;
      if (peak_mag !== '0) begin
         miscompares++;
         $display("FAIL %s.mag: got %0d expected 0", name, peak_mag);
      end
      vectors++;
      if (overrun !== exp_overrun) begin
         miscompares++;
         $display("FAIL %s.overrun: got %b expected %b", name, overrun, exp_overrun);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset", 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_linear();
      for (int i = 0; i < NFFT; i++) fmag[i] = MW'(i * 3);
      fmag[40] = 5000;
      drive_frame("linear", 1'b1, 1'b0, 1'b1, 8'd40, 33'd5000);
      // accepted on the edge after the check
      check_idle_outputs("linear_accepted", 1'b0);
   endtask

   task automatic test_dc_excluded();
      fill('0);
      fmag[0]  = 99999;
      fmag[10] = 200;
      drive_frame("dc_excluded", 1'b1, 1'b0, 1'b1, 8'd10, 33'd200);
   endtask

   task automatic test_tie();
      fill(33'd1);
      fmag[20] = 777;
      fmag[50] = 777;
      drive_frame("tie", 1'b1, 1'b0, 1'b1, 8'd20, 33'd777);
   endtask

   task automatic test_back_to_back();
      // window low edge: DC is biggest but excluded, bin 1 wins
      for (int i = 0; i < NFFT; i++) fmag[i] = MW'(1000 - i);
      drive_frame("b2b_lo_edge", 1'b1, 1'b0, 1'b1, 8'd1, 33'd999);
      // window high edge, no SOP (counter wrap), with gaps between beats
      for (int i = 0; i < NFFT; i++) fmag[i] = MW'(i);
      fmag[127] = 7000;
      fmag[128] = 9000;
      drive_frame("b2b_hi_edge_gaps", 1'b0, 1'b1, 1'b1, 8'd127, 33'd7000);
   endtask

   task automatic test_sop_mid_frame();
      fill(33'd1);
      fmag[30] = 60000;
      drive_partial(61);
      check_idle_outputs("sop_partial", 1'b0);
      fill(33'd1);
      fmag[100] = 2222;
      drive_frame("sop_new_frame", 1'b1, 1'b0, 1'b1, 8'd100, 33'd2222);
   endtask

   task automatic test_overrun();
      peak_ready = 1'b0;
      fill(33'd1);
      fmag[30] = 1234;
      drive_frame("overrun_first", 1'b1, 1'b0, 1'b1, 8'd30, 33'd1234);
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL overrun_first.overrun: got %b expected 0", overrun);
      end
      fill(33'd1);
      fmag[90] = 4321;
      // second frame's result is dropped; first stays on the outputs
      drive_frame("overrun_second", 1'b0, 1'b0, 1'b1, 8'd30, 33'd1234);
      peak_ready = 1'b1;
      @(negedge clk);
      check_idle_outputs("overrun_released", 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      peak_ready = 1'b0;
      fill(33'd1);
      fmag[70] = 3333;
      drive_frame("pre_reset", 1'b1, 1'b0, 1'b1, 8'd70, 33'd3333);
      fmag[20] = 8888;
      drive_partial(40);
      #2 reset = 1'b1;
      #1 check_idle_outputs("async_reset", 1'b0);
      @(negedge clk);
      reset      = 1'b0;
      peak_ready = 1'b1;
      fill(33'd2);
      fmag[12] = 4444;
      // no SOP: the counter must restart from bin 0 after reset
      drive_frame("post_reset", 1'b0, 1'b0, 1'b1, 8'd12, 33'd4444);
   endtask

`ifdef PEAK_THRESH_EN
   task automatic test_thresh();
      peak_thresh = 33'd1000;
      fill('0);
      fmag[5] = 900;
      drive_frame("thresh_below", 1'b1, 1'b0, 1'b0, 8'd0, 33'd0);
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL thresh_below.overrun: got %b expected 0", overrun);
      end
      fmag[5] = 1001;
      drive_frame("thresh_above", 1'b1, 1'b0, 1'b1, 8'd5, 33'd1001);
      peak_thresh = '0;
   endtask
`endif

   initial begin
      reset      = 1'b1;
      mag_valid  = 1'b0;
      mag_sop    = 1'b0;
      mag_sq     = '0;
      peak_ready = 1'b1;
`ifdef PEAK_THRESH_EN
      peak_thresh = '0;
`endif
      test_reset();
      test_linear();
      test_dc_excluded();
      test_tie();
      test_back_to_back();
      test_sop_mid_frame();
      test_overrun();
      test_reset_mid_frame();
`ifdef PEAK_THRESH_EN
      test_thresh();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
